// File: rtl/multi_port_fifo.sv
// rtl/multi_port_fifo.sv - multi-lane in-order FIFO with FWFT read lanes, credits and flush
//
// Purpose: buffers up to WR_PORTS pushes and retires up to RD_PORTS pops per
// cycle, strictly in order, for front-end pipeline queues.
//
// Ports:
//   clk_i          clock, all state on the rising edge
//   rst_i          synchronous active-high reset
//   flush_i        synchronous discard of all contents (pushes/pops ignored)
//   wr_num_i       number of write lanes offered (lanes 0..wr_num_i-1)
//   data_in_i      packed write lanes, lane i at [i*WIDTH +: WIDTH]
//   wr_accepted_o  number of lanes actually written this cycle
//   rd_num_i       number of entries the consumer takes this cycle
//   data_out_o     FWFT read lanes, lane i = entry at rd_ptr+i
//   rd_valid_o     lane i valid iff i < count
//   count_o        occupied entries
//   free_cnt_o     DEPTH - count
//   empty_o        count == 0
//   full_o         count == DEPTH
module multi_port_fifo #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 16,
   parameter int WR_PORTS = 3,
   parameter int RD_PORTS = 3
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   input  logic [$clog2(WR_PORTS+1)-1:0]     wr_num_i,
   input  logic [WR_PORTS*WIDTH-1:0]         data_in_i,
   output logic [$clog2(WR_PORTS+1)-1:0]     wr_accepted_o,
   input  logic [$clog2(RD_PORTS+1)-1:0]     rd_num_i,
   output logic [RD_PORTS*WIDTH-1:0]         data_out_o,
   output logic [RD_PORTS-1:0]               rd_valid_o,
   output logic [$clog2(DEPTH+1)-1:0]        count_o,
   output logic [$clog2(DEPTH+1)-1:0]        free_cnt_o,
   output logic                              empty_o,
   output logic                              full_o
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = $clog2(DEPTH+1);
   localparam int WNW = $clog2(WR_PORTS+1);
   localparam int RNW = $clog2(RD_PORTS+1);
   // Common comparison widths so min() never truncates either operand.
   localparam int XW  = (CW > WNW) ? CW : WNW;
   localparam int YW  = (CW > RNW) ? CW : RNW;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;

   logic [CW-1:0]    free_cnt;
   logic [XW-1:0]    wr_num_x, free_x, acc_x;
   logic [YW-1:0]    rd_num_y, count_y, take_y;
   logic [WNW-1:0]   wr_accepted;
   logic [RNW-1:0]   rd_taken;

   // Write room comes only from the registered count; same-cycle pops do not
   // free space, which keeps rd_num_i off every write-side path.
   always_comb begin
      free_cnt    = CW'(DEPTH) - count_q;
      wr_num_x    = XW'(wr_num_i);
      free_x      = XW'(free_cnt);
      acc_x       = (wr_num_x < free_x) ? wr_num_x : free_x;
      wr_accepted = (rst_i || flush_i) ? '0 : WNW'(acc_x);

      rd_num_y    = YW'(rd_num_i);
      count_y     = YW'(count_q);
      take_y      = (rd_num_y < count_y) ? rd_num_y : count_y;
      rd_taken    = RNW'(take_y);

      // Pointer sums truncate to PW bits, giving the modulo-DEPTH wrap.
      wr_ptr_d    = wr_ptr_q + PW'(wr_accepted);
      rd_ptr_d    = rd_ptr_q + PW'(rd_taken);
      count_d     = count_q + CW'(wr_accepted) - CW'(rd_taken);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; wr_accepted is already zero under rst/flush.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < WR_PORTS; i++) begin
         if (WNW'(i) < wr_accepted) begin
            mem_q[wr_ptr_q + PW'(i)] <= data_in_i[i*WIDTH +: WIDTH];
         end
      end
   end

   // FWFT lanes read straight from the array; no write-to-read bypass.
   always_comb begin
      for (int i = 0; i < RD_PORTS; i++) begin
         data_out_o[i*WIDTH +: WIDTH] = mem_q[rd_ptr_q + PW'(i)];
         rd_valid_o[i]                = (CW'(i) < count_q);
      end
   end

   assign wr_accepted_o = wr_accepted;
   assign count_o       = count_q;
   assign free_cnt_o    = free_cnt;
   assign empty_o       = (count_q == '0);
   assign full_o        = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_multi_port_fifo.sv
// tb/tb_multi_port_fifo.sv - scoreboard bench for multi_port_fifo
module tb_multi_port_fifo;

   localparam int W = 32;
   localparam int D = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [1:0]  wr_num = '0;
   logic [1:0]  rd_num = '0;
   logic [95:0] data_in = '0;
   logic [1:0]  wr_accepted;
   logic [95:0] data_out;
   logic [2:0]  rd_valid;
   logic [4:0]  count;
   logic [4:0]  free_cnt;
   logic        empty;
   logic        full;

   always #5 clk = ~clk;

   multi_port_fifo #(.WIDTH(32), .DEPTH(16), .WR_PORTS(3), .RD_PORTS(3)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .wr_num_i(wr_num), .data_in_i(data_in), .wr_accepted_o(wr_accepted),
      .rd_num_i(rd_num), .data_out_o(data_out), .rd_valid_o(rd_valid),
      .count_o(count), .free_cnt_o(free_cnt), .empty_o(empty), .full_o(full)
   );

   typedef struct {
      int          acc;
      int          exp_cnt;
      bit          chk;
      logic [95:0] d;
   } txn_t;

   txn_t        tq[$];
   logic [31:0] sb[$];
   int          mcnt = 0;
   bit          started = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // One cycle of stimulus. exp_acc < 0 means derive it from the count model.
   task automatic step(input int wn, input int rn, input bit fl, input bit rs,
                       input logic [95:0] d, input int exp_acc, input int exp_cnt);
      txn_t t;
      int   acc;
      @(posedge clk);
      #1;
      rst     = rs;
      flush   = fl;
      wr_num  = wn[1:0];
      rd_num  = rn[1:0];
      data_in = d;
      acc = exp_acc;
      if (acc < 0) acc = (rs || fl) ? 0 : imin(wn, D - mcnt);
      t.acc     = acc;
      t.exp_cnt = exp_cnt;
      t.chk     = started;
      t.d       = d;
      tq.push_back(t);
      started = 1'b1;
      if (rs || fl) mcnt = 0;
      else          mcnt = mcnt + acc - imin(rn, mcnt);
   endtask

   // Monitor: compares DUT outputs against the scoreboard, then applies the edge.
   initial begin
      txn_t t;
      int   n;
      int   take;
      forever begin
         @(negedge clk);
         if (tq.size() > 0) begin
            t = tq.pop_front();
            chk("wr_accepted", 32'(wr_accepted), 32'(t.acc));
            if (t.chk) begin
               n = sb.size();
               chk("count", 32'(count), 32'(n));
               chk("free_cnt", 32'(free_cnt), 32'(D - n));
               chk("empty", 32'(empty), 32'(n == 0));
               chk("full", 32'(full), 32'(n == D));
               chk("rd_valid", 32'(rd_valid), (n >= 3) ? 32'd7 : ((32'd1 << n) - 32'd1));
               for (int i = 0; i < imin(n, 3); i++)
                  chk($sformatf("data_out[%0d]", i), data_out[i*W +: W], sb[i]);
               if (t.exp_cnt >= 0)
                  chk("count_directed", 32'(count), 32'(t.exp_cnt));
            end
            if (rst || flush) begin
               sb.delete();
            end else begin
               take = imin(int'(rd_num), sb.size());
               repeat (take) void'(sb.pop_front());
               for (int i = 0; i < t.acc; i++) sb.push_back(t.d[i*W +: W]);
            end
         end
      end
   end

   localparam logic [95:0] FILL = {32'h12, 32'h11, 32'h10};
   localparam logic [95:0] ABC  = {32'hC0C0_000C, 32'hB0B0_000B, 32'hA0A0_000A};

   initial begin
      logic [95:0] rd;
      // Reset for two cycles.
      step(0, 0, 0, 1, '0, 0, -1);
      step(0, 0, 0, 1, '0, 0, 0);
      // Fill: last push only gets one slot.
      step(3, 0, 0, 0, FILL, 3, 0);
      step(3, 0, 0, 0, FILL, 3, 3);
      step(3, 0, 0, 0, FILL, 3, 6);
      step(3, 0, 0, 0, FILL, 3, 9);
      step(3, 0, 0, 0, FILL, 3, 12);
      step(3, 0, 0, 0, FILL, 1, 15);
      // Full with push and pop: pop proceeds, nothing accepted.
      step(3, 2, 0, 0, {32'h22, 32'h21, 32'h20}, 0, 16);
      step(3, 0, 0, 0, {32'h32, 32'h31, 32'h30}, 2, 14);
      // Drain three per cycle; last cycle shows a single valid lane.
      step(0, 3, 0, 0, '0, 0, 16);
      step(0, 3, 0, 0, '0, 0, 13);
      step(0, 3, 0, 0, '0, 0, 10);
      step(0, 3, 0, 0, '0, 0, 7);
      step(0, 3, 0, 0, '0, 0, 4);
      step(0, 3, 0, 0, '0, 0, 1);
      // Empty with push and pop: nothing popped, push lands.
      step(2, 3, 0, 0, {32'h0, 32'h41, 32'h40}, 2, 0);
      step(0, 3, 0, 0, '0, 0, 2);
      // Advance both pointers from 4 to 14.
      step(3, 0, 0, 0, {32'h52, 32'h51, 32'h50}, 3, 0);
      step(3, 0, 0, 0, {32'h55, 32'h54, 32'h53}, 3, 3);
      step(3, 0, 0, 0, {32'h58, 32'h57, 32'h56}, 3, 6);
      step(1, 0, 0, 0, {32'h0, 32'h0, 32'h59}, 1, 9);
      step(0, 3, 0, 0, '0, 0, 10);
      step(0, 3, 0, 0, '0, 0, 7);
      step(0, 3, 0, 0, '0, 0, 4);
      step(0, 1, 0, 0, '0, 0, 1);
      // Wrap: A,B,C land at 14,15,0 and read back next cycle.
      step(3, 0, 0, 0, ABC, 3, 0);
      step(0, 3, 0, 0, '0, 0, 3);
      // Flush at count 9 with push and pop offered.
      step(3, 0, 0, 0, {32'h62, 32'h61, 32'h60}, 3, 0);
      step(3, 0, 0, 0, {32'h65, 32'h64, 32'h63}, 3, 3);
      step(3, 0, 0, 0, {32'h68, 32'h67, 32'h66}, 3, 6);
      step(3, 1, 1, 0, {32'h6B, 32'h6A, 32'h69}, 0, 9);
      step(2, 0, 0, 0, {32'h0, 32'h71, 32'h70}, 2, 0);
      step(0, 2, 0, 0, '0, 0, 2);
      // Random soak with occasional flush.
      for (int c = 0; c < 10000; c++) begin
         rd = {$urandom(), $urandom(), $urandom()};
         step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 99) < 2), 1'b0, rd, -1, mcnt);
      end
      step(0, 0, 0, 0, '0, 0, mcnt);
      for (int i = 0; i < 10 && tq.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      n_chk++;
      if (tq.size() != 0) begin
         n_fail++;
         $display("FAIL monitor_drain: %0d transactions left, expected 0", tq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multi_port_fifo.md
# multi_port_fifo

Parametrised synchronous FIFO that accepts up to WR_PORTS entries and retires up to RD_PORTS entries per cycle, in order. It is the generalisation of the single-entry sync FIFO for the 3-wide front end: fetch-to-decode buffering and instruction queues between pipeline stages. It adds:
- first-word-fall-through (FWFT) read lanes;
- partial-acceptance handshakes on both sides;
- a free-slot count for upstream credit logic;
- a single-cycle flush for branch-mispredict recovery.

## Interface
- WIDTH, 32, bits per entry
- DEPTH, 16, entries; power of two, at least max(WR_PORTS, RD_PORTS)
- WR_PORTS, 3, maximum pushes per cycle
- RD_PORTS, 3, maximum pops per cycle

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, synchronous and active-high
- flush  in  1  synchronous discard of all contents
- wr_num  in  $clog2(WR_PORTS+1)  entries offered this cycle, lanes 0..wr_num-1
- data_in  in  WR_PORTS*WIDTH  packed write lanes; lane i at [i*WIDTH +: WIDTH]
- wr_accepted  out  $clog2(WR_PORTS+1)  entries actually written this cycle (combinational)
- rd_num  in  $clog2(RD_PORTS+1)  entries the consumer takes this cycle
- data_out  out  RD_PORTS*WIDTH  FWFT lanes; lane i = entry at rd_ptr+i (mod DEPTH)
- rd_valid  out  RD_PORTS  lane i valid iff i < count
- count  out  $clog2(DEPTH+1)  occupied entries (registered)
- free_cnt  out  $clog2(DEPTH+1)  DEPTH - count
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
State consists of:
- wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH;
- count, $clog2(DEPTH+1) bits;
- the storage array. The array is not reset; its contents are undefined until written.

Write side:
- wr_accepted = min(wr_num, free_cnt). free_cnt is the value at the start of the cycle; same-cycle pops do not create write room.
- Lanes 0..wr_accepted-1 are written to wr_ptr+0 .. wr_ptr+wr_accepted-1 (mod DEPTH). Remaining lanes are dropped.
- The producer must re-offer any rejected lanes in a later cycle.

Read side:
- rd_taken = min(rd_num, count). Taking more than rd_valid indicates is clamped, not an error.
- data_out and rd_valid are combinational from registered state; there is no write-to-read bypass.
- A pushed entry first appears on data_out in the cycle after it is written.
- Invalid lanes present stale array data; consumers must qualify them with rd_valid.

Update on each edge, in priority order:
- rst: wr_ptr, rd_ptr and count are cleared to 0.
- else flush: same as rst. Any same-cycle push or pop is ignored; wr_accepted is forced to 0 while flush is high.
- else:
  - wr_ptr += wr_accepted
  - rd_ptr += rd_taken
  - count += wr_accepted - rd_taken

Arithmetic rules:
- count arithmetic is exact in $clog2(DEPTH+1) bits.
- count ≤ DEPTH is invariant by construction.
- Pointer additions truncate, which gives the modulo-DEPTH wrap.

## Timing
- Reset values: count=0, free_cnt=DEPTH, empty=1, full=0, rd_valid=0, wr_accepted=0 during reset. data_out is undefined.
- Write-to-read latency is 1 cycle: pushed at edge N, visible with rd_valid at cycle N+1.
- Flush and reset take effect at the edge on which they are sampled high. The next cycle shows an empty FIFO.
- Reset or flush mid-stream discards all entries, including pushes offered in that cycle.
- Full with simultaneous push and pop: the pop proceeds, and wr_accepted=0 that cycle.
- Empty with simultaneous push and pop: nothing is popped, the push proceeds, and count = wr_accepted.
- Wrap-around: a multi-lane push or pop straddling index DEPTH-1 continues at index 0 in the same cycle.
- All outputs except data_out and rd_valid are pure functions of registered state and of wr_num/flush/rst; there is no combinational path from rd_num.

## Test plan
All scenarios use the default parameters (WIDTH=32, DEPTH=16, WR_PORTS=3, RD_PORTS=3).

- Reset and fill: hold rst for 2 cycles, then push wr_num=3 of values 0x10,0x11,0x12 for 6 cycles with rd_num=0 -> wr_accepted=3,3,3,3,3,1; count reaches 16, full=1; the last two lanes of the sixth push are dropped.
- Drain with FWFT: from the full state, rd_num=3 each cycle -> data_out lanes read back in order with rd_valid=3'b111 until the final cycle, which shows rd_valid=3'b001; then empty=1.
- Wrap-around: pre-advance both pointers to 14, then push 3 entries A,B,C -> entries land at indices 14, 15 and 0; the next cycle shows data_out = A,B,C with rd_valid=3'b111.
- Simultaneous push and pop at the boundaries:
  - count=16, wr_num=3, rd_num=2 -> wr_accepted=0, count=14;
  - count=0, wr_num=2, rd_num=3 -> rd_valid=0, count=2 next cycle.
- Flush: count=9, assert flush together with wr_num=3 and rd_num=1 -> wr_accepted=0; next cycle count=0, empty=1, free_cnt=16; a push in the following cycle is read back correctly.
- Random soak: 10k cycles of random wr_num, rd_num and flush (flush at 2% of cycles) against a queue scoreboard -> no ordering or data mismatch, and count always equals the scoreboard size.
